wrsw_ep_cfg_arbiter: RTL and testbench

//  Round-robin arbiter sharing one pipelined Wishbone master (register bus of the
//  per-port endpoints / switch core) between g_num_req configuration requesters
//  (CPU bridge, per-port link/PHY managers). Each requester issues single 32-bit

---
 rtl/wrsw_ep_cfg_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wrsw_ep_cfg_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wrsw_ep_cfg_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone master between g_num_req
// configuration requesters. One single-beat transaction on the bus at a time, with timeout.
module wrsw_ep_cfg_arbiter #(
  parameter int unsigned g_num_req = 6,
  parameter int unsigned g_timeout = 255
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_i,
  input  logic [g_num_req-1:0]     req_i,
  input  logic [g_num_req-1:0]     we_i,
  input  logic [32*g_num_req-1:0]  adr_i,
  input  logic [32*g_num_req-1:0]  dat_i,
  input  logic [4*g_num_req-1:0]   sel_i,
  output logic [g_num_req-1:0]     gnt_o,
  output logic [g_num_req-1:0]     done_o,
  output logic [g_num_req-1:0]     err_o,
  output logic [31:0]              rdata_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [31:0]              wb_adr_o,
  output logic [3:0]               wb_sel_o,
  output logic [31:0]              wb_dat_o,
  input  logic [31:0]              wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_stall_i
);

  localparam int unsigned IdxW = (g_num_req > 1) ? $clog2(g_num_req) : 1;
  localparam int unsigned TmrW = $clog2(g_timeout + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StDone} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [TmrW-1:0]      timer_q, timer_d;
  logic [g_num_req-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [31:0]          rdata_q, rdata_d, adr_q, adr_d, dat_q, dat_d;
  logic [3:0]           sel_q, sel_d;
  logic                 cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;

  logic                 found, finish, fail;
  int unsigned          cand, win;

  // First requester strictly after the rr pointer wins; the last winner ranks lowest.
  always_comb begin
    found = 1'b0;
    cand  = 0;
    win   = 0;
    for (int unsigned i = 1; i <= g_num_req; i++) begin
      cand = (32'(rr_q) + i) % g_num_req;
      if (!found && req_i[IdxW'(cand)]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    finish  = 1'b0;
    fail    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          we_d              = we_i[IdxW'(win)];
          adr_d             = adr_i[32*win +: 32];
          dat_d             = dat_i[32*win +: 32];
          sel_d             = sel_i[4*win +: 4];
          gnt_d             = '0;
          gnt_d[IdxW'(win)] = 1'b1;
          rr_d              = IdxW'(win);
          cyc_d             = 1'b1;
          stb_d             = 1'b1;
          timer_d           = '0;
          state_d           = StIssue;
        end
      end

      StIssue, StWaitAck: begin
        timer_d = timer_q + 1'b1;
        // err wins over a simultaneous ack; the slave may answer in the accept cycle
        if (wb_err_i) begin
          finish = 1'b1;
          fail   = 1'b1;
        end else if (wb_ack_i) begin
          finish = 1'b1;
          if (!we_q) rdata_d = wb_dat_i;
        end else if (timer_q == TmrW'(g_timeout - 1)) begin
          finish = 1'b1;
          fail   = 1'b1;
        end

        if (finish) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          gnt_d   = '0;
          done_d  = gnt_q;
          err_d   = fail ? gnt_q : '0;
          state_d = StDone;
        end else if (state_q == StIssue && !wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = StWaitAck;
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rr_q    <= IdxW'(g_num_req - 1);
      timer_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_wrsw_ep_cfg_arbiter.sv
// Directed bench for wrsw_ep_cfg_arbiter: arbitration order, stalls, read data,
// timeout, bus error and asynchronous reset mid-transaction.
module tb_wrsw_ep_cfg_arbiter;

  localparam int unsigned N = 6;

  logic            clk_sys_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i, we_i;
  logic [32*N-1:0] adr_i, dat_i;
  logic [4*N-1:0]  sel_i;
  logic [N-1:0]    gnt_o, done_o, err_o;
  logic [31:0]     rdata_o, wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]      wb_sel_o;
  logic            wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i, wb_stall_i;

  int n_cmp = 0;
  int n_err = 0;

  wrsw_ep_cfg_arbiter #(
    .g_num_req (N),
    .g_timeout (16)
  ) dut (
    .clk_sys_i  (clk_sys_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .sel_i      (sel_i),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rdata_o    (rdata_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_stall_i (wb_stall_i)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic step();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    req_i[k]           = 1'b1;
    we_i[k]            = we;
    adr_i[32*k +: 32]  = adr;
    dat_i[32*k +: 32]  = dat;
    sel_i[4*k +: 4]    = sel;
  endtask

  initial begin
    rst_i = 1'b1;
    req_i = '0; we_i = '0; adr_i = '0; dat_i = '0; sel_i = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
    step(); step();
    chk("rst_cyc", 32'(wb_cyc_o), 0);
    chk("rst_stb", 32'(wb_stb_o), 0);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    rst_i = 1'b0;
    step();

    // 1: single write from requester 2
    set_req(2, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    step();
    chk("t1_cyc", 32'(wb_cyc_o), 1);
    chk("t1_stb", 32'(wb_stb_o), 1);
    chk("t1_gnt", 32'(gnt_o), 32'b000100);
    chk("t1_adr", wb_adr_o, 32'h100);
    chk("t1_dat", wb_dat_o, 32'hDEADBEEF);
    chk("t1_sel", 32'(wb_sel_o), 32'hF);
    chk("t1_we", 32'(wb_we_o), 1);
    step();
    chk("t1_stb_drop", 32'(wb_stb_o), 0);
    chk("t1_cyc_hold", 32'(wb_cyc_o), 1);
    chk("t1_no_done", 32'(done_o), 0);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    req_i = '0;
    chk("t1_done", 32'(done_o), 32'b000100);
    chk("t1_err", 32'(err_o), 0);
    chk("t1_cyc_end", 32'(wb_cyc_o), 0);
    chk("t1_gnt_end", 32'(gnt_o), 0);
    step();
    chk("t1_done_pulse", 32'(done_o), 0);

    // 2: all requesters held, zero-wait slave; start from a fresh rr pointer
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    for (int k = 0; k < int'(N); k++) set_req(k, 1'b0, 32'h1000 + 32'(k) * 4, '0, 4'hF);
    for (int t = 0; t < 7; t++) begin
      int e;
      e = t % int'(N);
      step();
      chk("t2_gnt", 32'(gnt_o), 32'd1 << e);
      chk("t2_adr", wb_adr_o, 32'h1000 + 32'(e) * 4);
      step();
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hA000_0000 + 32'(t);
      step();
      wb_ack_i = 1'b0;
      chk("t2_done", 32'(done_o), 32'd1 << e);
      chk("t2_rdata", rdata_o, 32'hA000_0000 + 32'(t));
      chk("t2_gap_done", 32'(wb_cyc_o), 0);
      step();
      chk("t2_gap_idle", 32'(wb_cyc_o), 0);
    end
    req_i = '0;
    step(); step();

    // 3: read from requester 1 with three stall cycles
    set_req(1, 1'b0, 32'h200, '0, 4'hF);
    wb_stall_i = 1'b1;
    step();
    chk("t3_gnt", 32'(gnt_o), 32'b000010);
    chk("t3_stb0", 32'(wb_stb_o), 1);
    step();
    chk("t3_stb1", 32'(wb_stb_o), 1);
    step();
    chk("t3_stb2", 32'(wb_stb_o), 1);
    step();
    chk("t3_stb3", 32'(wb_stb_o), 1);
    wb_stall_i = 1'b0;
    step();
    chk("t3_stb_drop", 32'(wb_stb_o), 0);
    chk("t3_cyc", 32'(wb_cyc_o), 1);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h12345678;
    step();
    wb_ack_i = 1'b0;
    req_i = '0;
    chk("t3_done", 32'(done_o), 32'b000010);
    chk("t3_err", 32'(err_o), 0);
    chk("t3_rdata", rdata_o, 32'h12345678);
    step();

    // 4: timeout with slave never answering, then a stray late ack
    set_req(3, 1'b1, 32'h300, 32'h55, 4'h3);
    step();
    chk("t4_cyc_start", 32'(wb_cyc_o), 1);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("t4_cyc_hold", 32'(wb_cyc_o), 1);
    end
    step();
    req_i = '0;
    chk("t4_cyc_drop", 32'(wb_cyc_o), 0);
    chk("t4_done", 32'(done_o), 32'b001000);
    chk("t4_err", 32'(err_o), 32'b001000);
    step();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hBAD0BAD0;
    step();
    wb_ack_i = 1'b0;
    chk("t4_late_done", 32'(done_o), 0);
    chk("t4_late_err", 32'(err_o), 0);
    chk("t4_late_cyc", 32'(wb_cyc_o), 0);
    chk("t4_rdata", rdata_o, 32'h12345678);
    step();

    // 5: bus error (with simultaneous ack) on read from requester 4
    set_req(4, 1'b0, 32'h400, '0, 4'hF);
    step();
    chk("t5_gnt", 32'(gnt_o), 32'b010000);
    step();
    wb_err_i = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    step();
    wb_err_i = 1'b0;
    wb_ack_i = 1'b0;
    req_i = '0;
    chk("t5_done", 32'(done_o), 32'b010000);
    chk("t5_err", 32'(err_o), 32'b010000);
    chk("t5_rdata", rdata_o, 32'h12345678);
    step();

    // 6: asynchronous reset while waiting for ack
    set_req(5, 1'b0, 32'h500, '0, 4'hF);
    step();
    chk("t6_gnt", 32'(gnt_o), 32'b100000);
    step();
    chk("t6_cyc_wait", 32'(wb_cyc_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_cyc", 32'(wb_cyc_o), 0);
    chk("t6_rst_stb", 32'(wb_stb_o), 0);
    chk("t6_rst_gnt", 32'(gnt_o), 0);
    step();
    chk("t6_rst_done", 32'(done_o), 0);
    rst_i = 1'b0;
    set_req(0, 1'b0, 32'h600, '0, 4'hF);
    step();
    chk("t6_first_gnt", 32'(gnt_o), 32'b000001);
    chk("t6_first_adr", wb_adr_o, 32'h600);
    step();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE0001;
    step();
    wb_ack_i = 1'b0;
    req_i = '0;
    chk("t6_done", 32'(done_o), 32'b000001);
    chk("t6_rdata", rdata_o, 32'hCAFE0001);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
